pc_fetch_unit: RTL and testbench

Instruction-fetch front end for the X9 8-bit core. It holds the program counter, drives the instruction ROM address, and registers the returned 9-bit instruction for the decode/execute stage. Taken branches resolve through an internal writable branch-target LUT. The block detects the halt instruction and raises the sticky `done` flag that top level exports to the bench.

---
 rtl/pc_fetch_unit.sv | 68 ++++++
 tb/tb_pc_fetch_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, ROM fetch, branch-target LUT and halt detection for the X9 core
module pc_fetch_unit #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 9,
  parameter int LUT_AW = 5,
  parameter logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_en,
  input  logic [LUT_AW-1:0]  branch_idx,
  input  logic               lut_we,
  input  logic [LUT_AW-1:0]  lut_waddr,
  input  logic [PC_W-1:0]    lut_wdata,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               done
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic valid_n, done_n;
  logic [PC_W-1:0] lut [2**LUT_AW];
  assign rom_addr = pc;
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = instr;
    valid_n = instr_valid;
    done_n = done;
    if (state == HALTED) valid_n = 1'b0;
    else if (branch_en) begin
      pc_n = lut[branch_idx];
      instr_n = '0;
      valid_n = 1'b0;
    end else if (!stall) begin
      instr_n = rom_data;
      valid_n = 1'b1;
      // the halt word is captured but the pc stays on it
      if (rom_data == HALT_INSTR) begin
        done_n = 1'b1;
        state_n = HALTED;
      end else pc_n = pc + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc <= '0;
      instr <= '0;
      instr_valid <= 1'b0;
      done <= 1'b0;
      for (int i = 0; i < 2**LUT_AW; i++) lut[i] <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      instr <= instr_n;
      instr_valid <= valid_n;
      done <= done_n;
      if (lut_we) lut[lut_waddr] <= lut_wdata;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a behavioural fetch model
module tb_pc_fetch_unit;
  localparam logic [8:0] HALT = 9'h1FF;
  logic clk = 1'b0;
  logic reset, stall, branch_en, lut_we;
  logic [4:0] branch_idx, lut_waddr;
  logic [9:0] lut_wdata, rom_addr, pc;
  logic [8:0] rom_data, instr;
  logic instr_valid, done;
  logic [8:0] rom [1024];
  int n_cmp = 0, n_bad = 0;
  int m_pc, m_instr, m_valid, m_done, m_halt;
  int m_lut [32];
  bit chk = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en), .branch_idx(branch_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .rom_addr(rom_addr),
    .rom_data(rom_data), .pc(pc), .instr(instr), .instr_valid(instr_valid), .done(done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: once halted nothing but the LUT moves; otherwise branch beats stall beats fetch.
  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_instr = 0; m_valid = 0; m_done = 0; m_halt = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      chk = 1;
    end else begin
      if (m_halt) m_valid = 0;
      else if (branch_en) begin
        m_pc = m_lut[branch_idx]; m_instr = 0; m_valid = 0;
      end else if (!stall) begin
        m_instr = rom[m_pc]; m_valid = 1;
        if (rom[m_pc] == HALT) begin m_done = 1; m_halt = 1; end
        else m_pc = (m_pc + 1) % 1024;
      end
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
    end
  end

  always @(negedge clk) if (chk) begin
    check("m_pc", pc, m_pc);
    check("m_rom_addr", rom_addr, m_pc);
    check("m_instr", instr, m_instr);
    check("m_valid", instr_valid, m_valid);
    check("m_done", done, m_done);
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input int epc, input int einstr, input int evalid, input int edone);
    check("lit_pc", pc, epc);
    check("lit_instr", instr, einstr);
    check("lit_valid", instr_valid, evalid);
    check("lit_done", done, edone);
  endtask

  initial begin
    reset = 1; stall = 0; branch_en = 0; lut_we = 0;
    branch_idx = 0; lut_waddr = 0; lut_wdata = 0;
    foreach (rom[i]) rom[i] = 9'($urandom_range(0, 510));
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003; rom[3] = 9'h004;
    rom[6] = HALT; rom[700] = HALT;
    step(2);
    lit(0, 0, 0, 0);
    reset = 0;
    step; lit(1, 9'h001, 1, 0);
    step; lit(2, 9'h002, 1, 0);
    step; lit(3, 9'h003, 1, 0);
    lut_we = 1; lut_waddr = 3; lut_wdata = 10'd40;
    step; lit(4, 9'h004, 1, 0);
    lut_we = 0;
    step; check("pc5", pc, 5);
    branch_en = 1; branch_idx = 3;
    step; lit(40, 0, 0, 0);
    branch_en = 0;
    step; lit(41, rom[40], 1, 0);
    branch_en = 1; stall = 1;
    step; lit(40, 0, 0, 0);
    branch_en = 0; stall = 0;
    step; lit(41, rom[40], 1, 0);
    stall = 1;
    repeat (3) begin step; lit(41, rom[40], 1, 0); end
    stall = 0;
    step; lit(42, rom[41], 1, 0);
    lut_we = 1; lut_waddr = 2; lut_wdata = 10'd20;
    step;
    lut_wdata = 10'd100; branch_en = 1; branch_idx = 2;
    step; check("collide_pc", pc, 20);
    lut_we = 0;
    step; check("after_write_pc", pc, 100);
    branch_en = 0; lut_we = 1; lut_waddr = 5; lut_wdata = 10'd1023;
    step;
    lut_we = 0; branch_en = 1; branch_idx = 5;
    step; lit(1023, 0, 0, 0);
    branch_en = 0;
    step; lit(0, rom[1023], 1, 0);
    step(6); check("pre_halt_pc", pc, 6);
    step; lit(6, HALT, 1, 1);
    step; lit(6, HALT, 0, 1);
    branch_en = 1; branch_idx = 3; stall = 1;
    step(3); lit(6, HALT, 0, 1);
    branch_en = 0; stall = 0;
    reset = 1;
    step; lit(0, 0, 0, 0);
    reset = 0;
    step; lit(1, 9'h001, 1, 0);
    branch_en = 1; branch_idx = 3; reset = 1;
    step; lit(0, 0, 0, 0);
    reset = 0;
    step; lit(0, 0, 0, 0);
    branch_en = 0;
    step; lit(1, 9'h001, 1, 0);
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      branch_en = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 5) == 0);
      branch_idx = 5'($urandom_range(0, 31));
      lut_we = ($urandom_range(0, 3) == 0);
      lut_waddr = ($urandom_range(0, 1) == 0) ? branch_idx : 5'($urandom_range(0, 31));
      lut_wdata = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
      step;
    end
    reset = 0; branch_en = 0; stall = 0; lut_we = 0;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
